// File: rtl/ledpattern_pkg.sv
// Shared types for the LED pattern engine: mode encodings and direction values.
// Imported by ledpattern and ledpattern_chan.
package ledpattern_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_MANUAL  = 2'd3
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/ledpattern_chan.sv
// One LED channel: brightness register, fade step, optional gamma and the PWM compare.
// Build option: LEDPATTERN_GAMMA_EN replaces intermediate brightness with a squared curve.
module ledpattern_chan
    import ledpattern_pkg::*;
#(
    parameter int PWMBITS = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_clear,
    input  logic               i_tick,
    input  logic               i_fade,
    input  logic               i_breathe,
    input  logic               i_manual_mode,
    input  logic               i_owner,
    input  logic [PWMBITS-1:0] i_level,
    input  logic               i_manual,
    input  logic [PWMBITS-1:0] i_br,
    output logic               o_led
);

    localparam logic [PWMBITS-1:0] PWM_MAX = '1;

    logic [PWMBITS-1:0] pwm_q, pwm_d;
    logic [PWMBITS-1:0] decay;
    logic [PWMBITS-1:0] cmp;
    logic               led_q, led_d;
`ifdef LEDPATTERN_GAMMA_EN
    logic [2*PWMBITS-1:0] sq;
    logic [PWMBITS-1:0]   g;
`endif

    always_comb begin
        // Never underflows: pwm>>2 plus the nonzero term is at most pwm.
        decay = pwm_q - (pwm_q >> 2) - PWMBITS'(pwm_q != '0);
        pwm_d = pwm_q;
        if (i_clear) begin
            pwm_d = '0;
        end else if (i_tick) begin
            if (i_fade) begin
                pwm_d = i_owner ? PWM_MAX : decay;
            end else if (i_breathe) begin
                pwm_d = i_level;
            end
        end
    end

`ifdef LEDPATTERN_GAMMA_EN
    always_comb begin
        sq = {{PWMBITS{1'b0}}, pwm_q} * {{PWMBITS{1'b0}}, pwm_q};
        g  = sq[2*PWMBITS-1:PWMBITS];
        if (pwm_q == PWM_MAX) begin
            cmp = PWM_MAX;
        end else if (pwm_q == '0) begin
            cmp = '0;
        end else if (g == '0) begin
            cmp = PWMBITS'(1);
        end else begin
            cmp = g;
        end
    end
`else
    always_comb begin
        cmp = pwm_q;
    end
`endif

    always_comb begin
        led_d = 1'b0;
        if (i_manual_mode) begin
            led_d = i_manual;
        end else if (cmp == PWM_MAX) begin
            led_d = 1'b1;
        end else if (cmp == '0) begin
            led_d = 1'b0;
        end else begin
            led_d = (i_br <= cmp);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pwm_q <= '0;
            led_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
            led_q <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/ledpattern.sv
// Multi-mode LED pattern engine: prescaler, mode register and owner/dir/level sequencing.
// Build option: LEDPATTERN_GAMMA_EN (gamma-corrected brightness, handled per channel).
//
// mode         | meaning
// MODE_BOUNCE  | one-hot owner sweeps up and down with a one-tick dwell at each end
// MODE_CHASE   | one-hot owner rotates left, MSB wraps to bit0
// MODE_BREATHE | shared level ramps 0..MAX..0, every LED follows it
// MODE_MANUAL  | LEDs follow i_manual directly
module ledpattern
    import ledpattern_pkg::*;
#(
    parameter int NLEDS   = 8,
    parameter int CTRBITS = 25,
    parameter int PWMBITS = 5
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_mode_stb,
    input  logic [1:0]       i_mode,
    input  logic [NLEDS-1:0] i_manual,
    output logic [NLEDS-1:0] o_leds,
    output logic [1:0]       o_mode
);

    localparam logic [PWMBITS-1:0] LVL_MAX    = '1;
    localparam logic [NLEDS-1:0]   OWNER_INIT = NLEDS'(1);

    logic [CTRBITS-1:0] ctr_q, ctr_d;
    mode_t              mode_q, mode_d;
    logic [NLEDS-1:0]   owner_q, owner_d;
    logic               dir_q, dir_d;
    logic [PWMBITS-1:0] level_q, level_d;
    logic               tick;
    logic               step;
    logic [PWMBITS-1:0] br;
    logic               fade_en;
    logic               breathe_en;
    logic               manual_en;

    always_comb begin
        br = '0;
        for (int i = 0; i < PWMBITS; i++) begin
            br[i] = ctr_q[PWMBITS-1-i];
        end
    end

    always_comb begin
        ctr_d   = ctr_q + 1'b1;
        tick    = &ctr_q;
        mode_d  = mode_q;
        owner_d = owner_q;
        dir_d   = dir_q;
        level_d = level_q;
        step    = 1'b0;
        // Strobe outranks everything and swallows a coincident tick.
        if (i_mode_stb) begin
            mode_d  = mode_t'(i_mode);
            owner_d = OWNER_INIT;
            dir_d   = DIR_UP;
            level_d = '0;
        end else if (owner_q == '0) begin
            owner_d = OWNER_INIT;
            dir_d   = DIR_UP;
        end else if (tick) begin
            step = 1'b1;
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (owner_q[NLEDS-1]) dir_d = DIR_DOWN;
                        else                  owner_d = owner_q << 1;
                    end else begin
                        if (owner_q[0]) dir_d = DIR_UP;
                        else            owner_d = owner_q >> 1;
                    end
                end
                MODE_CHASE: begin
                    owner_d = (owner_q << 1) | (owner_q >> (NLEDS-1));
                end
                MODE_BREATHE: begin
                    if (dir_q == DIR_UP) begin
                        if (level_q == LVL_MAX) begin
                            dir_d   = DIR_DOWN;
                            level_d = LVL_MAX - 1'b1;
                        end else begin
                            level_d = level_q + 1'b1;
                        end
                    end else begin
                        if (level_q == '0) begin
                            dir_d   = DIR_UP;
                            level_d = PWMBITS'(1);
                        end else begin
                            level_d = level_q - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ctr_q   <= '0;
            mode_q  <= MODE_BOUNCE;
            owner_q <= OWNER_INIT;
            dir_q   <= DIR_UP;
            level_q <= '0;
        end else begin
            ctr_q   <= ctr_d;
            mode_q  <= mode_d;
            owner_q <= owner_d;
            dir_q   <= dir_d;
            level_q <= level_d;
        end
    end

    assign fade_en    = (mode_q == MODE_BOUNCE) || (mode_q == MODE_CHASE);
    assign breathe_en = (mode_q == MODE_BREATHE);
    assign manual_en  = (mode_q == MODE_MANUAL);
    assign o_mode     = mode_q;

    // Channels see next-state owner/level so the new owner lights on the same tick it gains ownership.
    for (genvar k = 0; k < NLEDS; k++) begin : g_chan
        ledpattern_chan #(
            .PWMBITS(PWMBITS)
        ) u_chan (
            .i_clk        (i_clk),
            .i_reset_n    (i_reset_n),
            .i_clear      (i_mode_stb),
            .i_tick       (step),
            .i_fade       (fade_en),
            .i_breathe    (breathe_en),
            .i_manual_mode(manual_en),
            .i_owner      (owner_d[k]),
            .i_level      (level_d),
            .i_manual     (i_manual[k]),
            .i_br         (br),
            .o_led        (o_leds[k])
        );
    end

endmodule

// File: tb/tb_ledpattern.sv
// Scoreboard bench for ledpattern: a behavioural pattern model queues the expected outputs,
// a negedge monitor compares them. Mirrors LEDPATTERN_GAMMA_EN when defined.
module tb_ledpattern;

    localparam int N     = 8;
    localparam int CB    = 6;
    localparam int PB    = 5;
    localparam int MAXV  = (1 << PB) - 1;
    localparam int TICKP = 1 << CB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode_stb;
    logic [1:0]   mode_in;
    logic [N-1:0] manual;
    logic [N-1:0] leds;
    logic [1:0]   omode;

    always #5 clk = ~clk;

    ledpattern #(.NLEDS(N), .CTRBITS(CB), .PWMBITS(PB)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_mode_stb(mode_stb),
        .i_mode    (mode_in),
        .i_manual  (manual),
        .o_leds    (leds),
        .o_mode    (omode)
    );

    typedef struct {
        logic [N-1:0] leds;
        logic [1:0]   mode;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: owner as an index, brightness as plain integers.
    int m_ctr   = 0;
    int m_mode  = 0;
    int m_pos   = 0;
    bit m_up    = 1'b1;
    int m_level = 0;
    int m_pwm[N];

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < PB; i++) if (v[i]) r = r | (1 << (PB - 1 - i));
        return r;
    endfunction

    function automatic int shade(input int p);
`ifdef LEDPATTERN_GAMMA_EN
        int g;
        if (p == 0 || p == MAXV) return p;
        g = (p * p) >> PB;
        return (g == 0) ? 1 : g;
`else
        return p;
`endif
    endfunction

    function automatic int decay(input int p);
        if (p == 0) return 0;
        return p - p / 4 - 1;
    endfunction

    always @(posedge clk) begin : model
        exp_t e;
        int   br;
        int   c;
        bit   tick;
        br = bitrev(m_ctr % (MAXV + 1));
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                e.leds[k] = 1'b0;
            end else if (m_mode == 3) begin
                e.leds[k] = manual[k];
            end else begin
                c = shade(m_pwm[k]);
                if (c == MAXV)   e.leds[k] = 1'b1;
                else if (c == 0) e.leds[k] = 1'b0;
                else             e.leds[k] = (br <= c);
            end
        end
        tick = (m_ctr == TICKP - 1);
        if (!rst_n) begin
            m_mode = 0; m_pos = 0; m_up = 1'b1; m_level = 0;
            for (int k = 0; k < N; k++) m_pwm[k] = 0;
        end else if (mode_stb) begin
            m_mode = int'(mode_in); m_pos = 0; m_up = 1'b1; m_level = 0;
            for (int k = 0; k < N; k++) m_pwm[k] = 0;
        end else if (tick) begin
            if (m_mode == 0 || m_mode == 1) begin
                if (m_mode == 1) begin
                    m_pos = (m_pos + 1) % N;
                end else if (m_up) begin
                    if (m_pos == N - 1) m_up = 1'b0; else m_pos++;
                end else begin
                    if (m_pos == 0) m_up = 1'b1; else m_pos--;
                end
                for (int k = 0; k < N; k++) m_pwm[k] = (k == m_pos) ? MAXV : decay(m_pwm[k]);
            end else if (m_mode == 2) begin
                if (m_up) begin
                    if (m_level == MAXV) begin m_up = 1'b0; m_level = MAXV - 1; end
                    else m_level++;
                end else begin
                    if (m_level == 0) begin m_up = 1'b1; m_level = 1; end
                    else m_level--;
                end
                for (int k = 0; k < N; k++) m_pwm[k] = m_level;
            end
        end
        m_ctr = (!rst_n) ? 0 : (m_ctr + 1) % TICKP;
        e.mode = 2'(m_mode);
        q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            tests++;
            if (leds !== e.leds) begin
                fails++;
                $display("FAIL o_leds at %0t: got %h expected %h", $time, leds, e.leds);
            end
            tests++;
            if (omode !== e.mode) begin
                fails++;
                $display("FAIL o_mode at %0t: got %0d expected %0d", $time, omode, e.mode);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic strobe(input logic [1:0] m);
        mode_in  = m;
        mode_stb = 1'b1;
        cyc(1);
        mode_stb = 1'b0;
    endtask

    task automatic strobe_on_tick(input logic [1:0] m);
        int budget = 2 * TICKP;
        while (m_ctr != TICKP - 1 && budget > 0) begin
            cyc(1);
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL tick_align: got no tick in %0d cycles expected one", 2 * TICKP);
        end
        strobe(m);
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_stb = 1'b0;
        mode_in  = 2'd0;
        manual   = '0;
        cyc(3);
        rst_n = 1'b1;
        cyc(17 * TICKP + 5);          // full bounce sweep plus dwell and decay
        strobe(2'd1);
        cyc(10 * TICKP);              // chase wraps past bit7
        strobe(2'd2);
        cyc(66 * TICKP);              // breathe up, down and back to 1
        manual = 8'hA5;
        strobe(2'd3);
        cyc(5);
        manual = 8'h3C;
        cyc(5);
        for (int i = 0; i < 40; i++) begin
            manual = N'($urandom);
            cyc(1);
        end
        strobe(2'd0);
        cyc(5 * TICKP + 7);
        strobe_on_tick(2'd1);         // tick dropped, chase starts at bit0
        cyc(3 * TICKP);
        strobe_on_tick(2'd1);         // same mode still restarts
        cyc(2 * TICKP);
        strobe(2'd2);
        cyc(20 * TICKP + 10);         // level 20
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(4 * TICKP);
        for (int i = 0; i < 40; i++) begin
            int gap;
            int act;
            gap = $urandom_range(1, 300);
            act = $urandom_range(0, 9);
            if (act == 0) begin
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end else if (act == 1) begin
                strobe_on_tick(2'($urandom));
            end else begin
                strobe(2'($urandom));
            end
            for (int j = 0; j < gap; j++) begin
                manual = N'($urandom);
                cyc(1);
            end
        end
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
